// File: rtl/mux_prox_instr_ctx_if.sv
// Bus between the control unit and the next-instruction unit.
// The control unit (master) drives the next-PC selection and trap requests;
// the next-instruction unit (slave) returns the PC and its context status.
interface mux_prox_instr_ctx_if #(
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic [2:0]        controle;
    logic [ADDR_W-1:0] desvio;
    logic [ADDR_W-1:0] end_imm;
    logic [ADDR_W-1:0] end_reg;
    logic              swap_SO;
    logic              status;
    logic [ADDR_W-1:0] pc;
    logic              in_so;
    logic [DW-1:0]     ctx_depth;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output stall, controle, desvio, end_imm, end_reg, swap_SO, status,
        input  pc, in_so, ctx_depth, stack_ovf, stack_unf
    );

    modport slave (
        input  stall, controle, desvio, end_imm, end_reg, swap_SO, status,
        output pc, in_so, ctx_depth, stack_ovf, stack_unf
    );
endinterface

// File: rtl/mux_prox_instr_ctx.sv
// Next-instruction unit: owns the PC register, selects the next fetch
// address, and keeps a LIFO of return addresses for OS entries (swap_SO).
// A halted processor (status=0) is parked on the OS vector. Overflow and
// underflow of the return stack are recorded in sticky flags.
module mux_prox_instr_ctx #(
    parameter int ADDR_W      = 32,
    parameter int OS_VECTOR   = 96,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_prox_instr_ctx_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {ST_RUN, ST_OS, ST_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] ret_val;
    logic [ADDR_W-1:0] top_val;
    logic              swap;
    logic              push_en;

    // Next-state, next-PC and stack control, in per-edge priority order
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        pc_inc  = pc_q + ADDR_W'(1);
        swap    = bus.swap_SO | pend_q;

        case (bus.controle)
            3'd1:    nxt = pc_q + bus.desvio;
            3'd2:    nxt = bus.end_imm;
            3'd3:    nxt = bus.end_reg;
            default: nxt = pc_inc;
        endcase

        // A pop or an unused code returns to the sequential successor
        ret_val = (bus.controle <= 3'd3) ? nxt : pc_inc;

        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i) == depth_q - DW'(1)) begin
                top_val = stack_q[i];
            end
        end

        if (!bus.status) begin
            pc_d    = ADDR_W'(OS_VECTOR);
            state_d = ST_HALT;
            pend_d  = pend_q | bus.swap_SO;
        end else if (state_q == ST_HALT) begin
            pc_d    = ADDR_W'(OS_VECTOR);
            state_d = (depth_q == '0) ? ST_RUN : ST_OS;
            pend_d  = pend_q | bus.swap_SO;
        end else if (bus.stall) begin
            pend_d  = pend_q | bus.swap_SO;
        end else if (swap) begin
            pc_d    = ADDR_W'(OS_VECTOR);
            pend_d  = 1'b0;
            state_d = ST_OS;
            if (depth_q == DW'(STACK_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (bus.controle == 3'd4) begin
            if (depth_q != '0) begin
                pc_d    = top_val;
                depth_d = depth_q - DW'(1);
                if (depth_q == DW'(1)) begin
                    state_d = ST_RUN;
                end
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else begin
            pc_d = nxt;
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            depth_q <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless above ctx_depth
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (rst_n && push_en && depth_q == DW'(i)) begin
                stack_q[i] <= ret_val;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.in_so     = (state_q == ST_OS);
    assign bus.ctx_depth = depth_q;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_mux_prox_instr_ctx.sv
// Scoreboard bench for mux_prox_instr_ctx with a two-entry return stack.
// Stimulus pushes hand-computed post-edge expectations; a monitor pops and
// compares them one cycle later.
module tb_mux_prox_instr_ctx;
    localparam int ADDR_W      = 32;
    localparam int OS_VECTOR   = 96;
    localparam int STACK_DEPTH = 2;
    localparam int DW          = $clog2(STACK_DEPTH + 1);

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              so;
        logic [DW-1:0]     depth;
        logic              ovf;
        logic              unf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycle;
    exp_t sb [$];

    mux_prox_instr_ctx_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    mux_prox_instr_ctx #(
        .ADDR_W(ADDR_W), .OS_VECTOR(OS_VECTOR), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [ADDR_W-1:0] act,
                               input logic [ADDR_W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge
    task automatic applyStimulus(input logic rst, input logic stl, input logic [2:0] ctl,
                                 input logic swp, input logic sts,
                                 input logic [ADDR_W-1:0] e_pc, input logic e_so,
                                 input logic [DW-1:0] e_d, input logic e_o, input logic e_u);
        exp_t e;
        @(negedge clk);
        rst_n        = rst;
        bus.stall    = stl;
        bus.controle = ctl;
        bus.swap_SO  = swp;
        bus.status   = sts;
        e.pc = e_pc; e.so = e_so; e.depth = e_d; e.ovf = e_o; e.unf = e_u;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per rising edge and compares every output
    initial begin
        exp_t e;
        cycle = 0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pc", bus.pc, e.pc);
                checkOutput("in_so", ADDR_W'(bus.in_so), ADDR_W'(e.so));
                checkOutput("ctx_depth", ADDR_W'(bus.ctx_depth), ADDR_W'(e.depth));
                checkOutput("stack_ovf", ADDR_W'(bus.stack_ovf), ADDR_W'(e.ovf));
                checkOutput("stack_unf", ADDR_W'(bus.stack_unf), ADDR_W'(e.unf));
            end
        end
    end

    initial begin
        int wait_cycles;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.controle = 3'd0; bus.swap_SO = 1'b0; bus.status = 1'b1;
        bus.desvio = '0; bus.end_imm = '0; bus.end_reg = '0;

        // Reset then sequential fetch
        applyStimulus(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1,  1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1,  2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1,  3, 0, 0, 0, 0);

        // Branch, immediate and register targets
        bus.end_imm = 32'd10;
        applyStimulus(1, 0, 2, 0, 1, 10, 0, 0, 0, 0);
        bus.desvio = -32'sd4;
        applyStimulus(1, 0, 1, 0, 1,  6, 0, 0, 0, 0);
        bus.end_imm = 32'd40;
        applyStimulus(1, 0, 2, 0, 1, 40, 0, 0, 0, 0);
        bus.end_reg = 32'd7;
        applyStimulus(1, 0, 3, 0, 1,  7, 0, 0, 0, 0);

        // Swap, run in OS, return
        bus.end_imm = 32'd20;
        applyStimulus(1, 0, 2, 0, 1, 20, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 97, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 98, 1, 1, 0, 0);
        applyStimulus(1, 0, 4, 0, 1, 21, 0, 0, 0, 0);

        // Swap alongside a branch saves the branch target
        bus.desvio = 32'd5;
        applyStimulus(1, 0, 1, 1, 1, 96, 1, 1, 0, 0);
        applyStimulus(1, 0, 4, 0, 1, 26, 0, 0, 0, 0);

        // Overflow with two entries, LIFO restore, then underflow
        bus.end_imm = 32'd5;
        applyStimulus(1, 0, 2, 0, 1,  5, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 2, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 2, 1, 0);
        applyStimulus(1, 0, 4, 0, 1, 97, 1, 1, 1, 0);
        applyStimulus(1, 0, 4, 0, 1,  6, 0, 0, 1, 0);
        applyStimulus(1, 0, 4, 0, 1,  7, 0, 0, 1, 1);

        // Swap wins over a simultaneous pop and saves PC+1
        applyStimulus(1, 0, 4, 1, 1, 96, 1, 1, 1, 1);
        applyStimulus(1, 0, 4, 0, 1,  8, 0, 0, 1, 1);

        // Swap pulse during stall is held until the stall lifts
        bus.end_imm = 32'd30;
        applyStimulus(1, 0, 2, 0, 1, 30, 0, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, 1, 30, 0, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 1, 30, 0, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 1, 30, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 96, 1, 1, 1, 1);
        applyStimulus(1, 0, 4, 0, 1, 31, 0, 0, 1, 1);

        // Halt parks on the OS vector, resume passes through it once
        bus.end_imm = 32'd50;
        applyStimulus(1, 0, 2, 0, 1, 50, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 96, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 96, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 96, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 97, 0, 0, 1, 1);

        // Address wraparound
        bus.end_imm = 32'hFFFF_FFFF;
        applyStimulus(1, 0, 2, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1);

        // Reset while two contexts are saved
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 1, 1, 1);
        applyStimulus(1, 0, 0, 1, 1, 96, 1, 2, 1, 1);
        applyStimulus(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1,  1, 0, 0, 0, 0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_prox_instr_ctx.md
Name: mux_prox_instr_ctx

Overview:
- Next-generation next-instruction unit: selects the next instruction address exactly as the current next-PC mux does, and additionally owns the PC register.
- Adds an OS context stack: each swap_SO saves the interrupted program's return address; controle=4 restores it.
- Adds stall hold, a pending-swap latch, a halt state and sticky error flags.
- Sits between the control unit and instruction memory; its pc output drives the instruction fetch address.

Parameters:
ADDR_W, 32, width of every address and the PC
OS_VECTOR, 96, OS entry address loaded on swap or halt
STACK_DEPTH, 4, number of saved return addresses (>=1); DW = clog2(STACK_DEPTH+1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
stall  in  1  1 = hold PC; no push or pop
controle  in  3  next-PC source: 0 PC+1, 1 PC+desvio, 2 end_imm, 3 end_reg, 4 pop return address, 5-7 PC+1
desvio  in  ADDR_W  signed branch offset, two's complement
end_imm  in  ADDR_W  absolute target taken from the immediate field
end_reg  in  ADDR_W  absolute target read from a register
swap_SO  in  1  request OS entry (single-cycle pulse or level)
status  in  1  0 = processor halted; forces the OS vector
pc  out  ADDR_W  current instruction address (registered)
in_so  out  1  1 while at least one context is saved (OS state)
ctx_depth  out  DW  number of saved entries
stack_ovf  out  1  sticky: a push was attempted while the stack was full
stack_unf  out  1  sticky: a pop was attempted while the stack was empty

Behaviour:
- Reset (rst_n=0 at clk edge): pc=0, ctx_depth=0, in_so=0, stack_ovf=0, stack_unf=0, pend=0, state=RUN. Reset takes priority over all other inputs, including mid-trap.
- Arithmetic: nxt is computed combinationally from controle 0-3: PC+1, PC+desvio, end_imm or end_reg. All sums are modulo 2^ADDR_W, so PC=all-ones with controle=0 gives 0.
- States: RUN (ctx_depth=0), OS (ctx_depth>0), HALT. in_so=1 exactly when state=OS.
- Swap request: swap = swap_SO | pend.
- Per-edge priority (highest first):
  1. status=0: pc<=OS_VECTOR, state<=HALT. No push or pop. pend<=pend|swap_SO. Overrides stall.
  2. status=1 in HALT: pc<=OS_VECTOR, state<=RUN if ctx_depth=0, else OS. Resumes normal decoding on the following cycle.
  3. stall=1: pc holds. pend<=pend|swap_SO. No push or pop.
  4. swap=1: push ret, pc<=OS_VECTOR, pend<=0, state<=OS.
     - ret = nxt for controle 0-3; ret = PC+1 for controle 4-7.
     - A simultaneous controle=4 pop is discarded.
  5. controle=4, ctx_depth>0: pc<=top of stack, ctx_depth-=1; state<=RUN if the result is 0.
  6. controle=4, ctx_depth=0: pc<=PC+1, stack_unf<=1.
  7. Otherwise: pc<=nxt (controle 5-7 behave as 0).
- Push when ctx_depth=STACK_DEPTH: entry dropped and depth unchanged. stack_ovf<=1. pc still <=OS_VECTOR.
- Nested swaps while in OS push further entries; restore order is LIFO.
- Latency: a request seen at edge N produces its pc value after edge N. A swap raised during stall is serviced at the first unstalled edge.
- The stack is plain registers; no read-during-write hazard exists because push and pop are exclusive.
- Sticky flags are cleared only by reset.

Test Plan:
- Reset, then 3 cycles with controle=0 -> pc 0,1,2,3; ctx_depth=0; in_so=0.
- pc=10, controle=1, desvio=-4 -> pc=6; then controle=2, end_imm=40 -> pc=40; then controle=3, end_reg=7 -> pc=7.
- pc=20, controle=0, swap_SO=1 -> pc=96, in_so=1, depth=1. Two cycles at controle=0 -> pc 97, 98. Then controle=4 -> pc=21, in_so=0.
- STACK_DEPTH=2: three swaps from pc 5, then 96, then 96 -> depth=2, stack_ovf=1. Two pops -> pc=97 then pc=6. Third pop -> stack_unf=1, pc=7.
- stall=1 with a swap_SO pulse at pc=30 -> pc holds at 30 for 3 stalled cycles. Release stall -> pc=96, return address 31 saved.
- status=0 for 2 cycles mid-program at pc=50 -> pc=96, ctx_depth unchanged. Then status=1 -> pc=96 once, then pc 97.
- Assert rst_n=0 while in OS at depth 2 -> next edge pc=0, depth=0, all flags 0.
